div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  input  1  request a division; sampled only in IDLE.
REQ-004 SHALL have: signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have: dividend_i  input  32  dividend, captured with start.
REQ-006 SHALL have: divisor_i  input  32  divisor, captured with start.
REQ-007 SHALL have: cancel  input  1  pipeline flush; abandons any operation in progress.
REQ-008 SHALL have: busy_o  output  1  high whenever state is not IDLE; used as the stall source.
REQ-009 SHALL have: valid_o  output  1  one-cycle result strobe; drives the HI/LO register write enable.
REQ-010 SHALL have: quotient_o  output  32  quotient; destined for LO.
REQ-011 SHALL have: remainder_o  output  32  remainder; destined for HI.
REQ-012 SHALL have: div_by_zero_o  output  1  high with valid_o when the captured divisor was 0.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL transition IDLE->RUN on start when cancel is low, latching operand magnitudes, signs, signed_i and an iteration counter of 0.
REQ-015 SHALL perform exactly one restoring shift/subtract iteration per RUN cycle, producing one quotient bit, MSB first.
REQ-016 SHALL transition RUN->DONE after the 32nd iteration and apply sign correction when entering DONE.
REQ-017 SHALL hold valid_o high for exactly one cycle (DONE), then return to IDLE.
REQ-018 SHALL have the following latency: start high in cycle 0 -> busy_o high in cycles 1..33, valid_o high in cycle 33 only, start accepted again from cycle 34.
REQ-019 SHALL ignore start while busy_o is high; operands are not re-captured.
REQ-020 SHALL, when signed_i is 1, negate the quotient iff the operand signs differ.
REQ-021 SHALL, when signed_i is 1, give the remainder the sign of the dividend.
REQ-022 SHALL, when signed_i is 1, produce for 0x80000000 / 0xFFFFFFFF quotient 0x80000000 and remainder 0, with no error flag.
REQ-023 SHALL register quotient_o, remainder_o and div_by_zero_o and hold them unchanged after DONE until the next result.
REQ-024 SHALL, on cancel in any state, go to IDLE at the next edge with no valid_o, leaving result outputs unchanged.
REQ-025 SHALL give cancel priority over start when both are high in the same cycle.

Reset
REQ-026 SHALL, on rst, move to IDLE and clear busy_o, valid_o, quotient_o, remainder_o, div_by_zero_o and the counter to 0 at the next edge.
REQ-027 SHALL let rst override cancel and start in any state, including mid-RUN and DONE.

Configuration
REQ-028 SHALL, with DIV_ZERO_SHORTCUT_EN defined, go IDLE->DONE directly on a zero divisor, giving valid_o in cycle 1, quotient_o = 0xFFFFFFFF, remainder_o = dividend_i and div_by_zero_o = 1.
REQ-029 SHALL, without DIV_ZERO_SHORTCUT_EN, run the full 33-cycle sequence for a zero divisor with div_by_zero_o = 1; quotient and remainder values are architecturally unpredictable and not checked.

Structure
REQ-030 SHALL define the state enum Div_state_t and the constant DIV_ITERS = 32 in the shared defines package, alongside Reg_data_t and Bit_t.
REQ-031 SHALL place one restoring iteration (shift, 33-bit subtract, select, quotient bit) in a combinational sub-module, div_step.

Verification
REQ-032 SHALL cover: unsigned 100 / 7 -> valid in cycle 33, q = 14, r = 2, dbz = 0.
REQ-033 SHALL cover: signed -7 / 2 -> q = 0xFFFFFFFD, r = 0xFFFFFFFF; signed 7 / -2 -> q = 0xFFFFFFFD, r = 1.
REQ-034 SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0; unsigned 0xFFFFFFFF / 1 -> q = 0xFFFFFFFF, r = 0.
REQ-035 SHALL cover: 5 / 0 with the macro -> valid in cycle 1, q = 0xFFFFFFFF, r = 5, dbz = 1; without the macro -> valid in cycle 33, dbz = 1.
REQ-036 SHALL cover: cancel in cycle 10 -> no valid_o, busy_o low in cycle 11, a new start in cycle 11 gives valid_o in cycle 44 with a correct result.
REQ-037 SHALL cover: rst in cycle 20 of a run -> all outputs 0 in cycle 21, no valid_o afterwards, start held high during rst ignored.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative 32-bit divider (div_unit).
package div_unit_pkg;

  typedef logic [31:0] Reg_data_t;
  typedef logic        Bit_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  typedef logic [CNT_W-1:0] Cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } Div_state_t;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic Reg_data_t cond_neg(input Bit_t neg, input Reg_data_t x);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial subtract,
// keep or restore the partial remainder and shift in one quotient bit.
module div_step
  import div_unit_pkg::*;
(
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_div,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  Bit_t        w_qbit;

  // Partial remainder stays below the divisor, so the shifted value fits in 33 bits.
  always_comb begin
    w_shift = {i_rem, i_quo[31]};
    w_diff  = w_shift - {1'b0, i_div};
    w_qbit  = ~w_diff[32];
    o_rem   = w_qbit ? w_diff[31:0] : w_shift[31:0];
    o_quo   = {i_quo[30:0], w_qbit};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: IDLE -> RUN (32 iterations) -> DONE, cancellable.
// Optional macro DIV_ZERO_SHORTCUT_EN: zero divisor goes straight to DONE.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        cancel,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_by_zero_o
);

  Div_state_t r_state;
  Div_state_t w_state_nxt;

  Reg_data_t  r_rem;
  Reg_data_t  r_quo;
  Reg_data_t  r_div;
  Bit_t       r_neg_q;
  Bit_t       r_neg_r;
  Bit_t       r_dbz;
  Cnt_t       r_cnt;

  Reg_data_t  w_rem;
  Reg_data_t  w_quo;
  Bit_t       w_a_neg;
  Bit_t       w_b_neg;
  Bit_t       w_zero;
  Bit_t       w_last;

  assign w_a_neg = signed_i & dividend_i[31];
  assign w_b_neg = signed_i & divisor_i[31];
  assign w_zero  = (divisor_i == '0);
  assign w_last  = (r_state == RUN) && (r_cnt == CNT_W'(DIV_ITERS - 1));

  assign busy_o  = (r_state != IDLE);
  assign valid_o = (r_state == DONE);

  div_step u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem),
    .o_quo (w_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          w_state_nxt = w_zero ? DONE : RUN;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (cancel) w_state_nxt = IDLE;
  end

  // The quotient register doubles as the dividend shifter: its MSB feeds each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_cnt         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else if (!cancel) begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_rem   <= '0;
            r_quo   <= cond_neg(w_a_neg, dividend_i);
            r_div   <= cond_neg(w_b_neg, divisor_i);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dbz   <= w_zero;
            r_cnt   <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (w_zero) begin
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            quotient_o    <= cond_neg(r_neg_q, w_quo);
            remainder_o   <= cond_neg(r_neg_r, w_rem);
            div_by_zero_o <= r_dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
